// File: rtl/batalha_pkg.sv
// Shared definitions for the battleship validation stage: piece encodings,
// piece sizes, board side, FSM states and the empty-cell code.
package batalha_pkg;

    localparam int LADO_PADRAO = 8;

    localparam logic [2:0] CELULA_VAZIA = 3'd0;

    typedef enum logic [2:0] {
        SUBMARINO    = 3'd0,
        CRUZADOR     = 3'd1,
        HIDROAVIAO   = 3'd2,
        ENCOURACADO  = 3'd3,
        PORTA_AVIOES = 3'd4
    } tipo_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        VERIFICA  = 2'd1,
        RESULTADO = 2'd2,
        GRAVA     = 2'd3
    } estado_t;

    // Number of cells per piece; undefined codes behave as a single cell.
    function automatic logic [2:0] tamanho_peca(input logic [2:0] tipo);
        case (tipo)
            SUBMARINO:    return 3'd1;
            CRUZADOR:     return 3'd2;
            HIDROAVIAO:   return 3'd3;
            ENCOURACADO:  return 3'd4;
            PORTA_AVIOES: return 3'd5;
            default:      return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/validador_pecas_if.sv
// Bundle between the placement FSM / game-execution stage and the piece
// validator: piece request, check/store status and the board read port.
interface validador_pecas_if;

    logic       valida;
    logic       armazena;
    logic [2:0] tipo;
    logic [3:0] X1;
    logic [3:0] Y1;
    logic       direcao;
    logic [2:0] orientacao;
    logic       jogador;

    logic       conflito;
    logic       verificado;
    logic       ocupado;
    logic       gravado;

    logic       rd_jogador;
    logic [3:0] rd_x;
    logic [3:0] rd_y;
    logic [2:0] rd_celula;

    modport master (
        output valida, armazena, tipo, X1, Y1, direcao, orientacao, jogador,
        output rd_jogador, rd_x, rd_y,
        input  conflito, verificado, ocupado, gravado, rd_celula
    );

    modport slave (
        input  valida, armazena, tipo, X1, Y1, direcao, orientacao, jogador,
        input  rd_jogador, rd_x, rd_y,
        output conflito, verificado, ocupado, gravado, rd_celula
    );

endinterface

// File: rtl/validador_pecas_gerador_celulas.sv
// Combinational cell walker: offset (dx, dy) of cell k of a piece relative
// to its anchor, plus a flag marking the piece's last cell.
module gerador_celulas
    import batalha_pkg::*;
(
    input  logic              [2:0] tipo,
    input  logic                    direcao,
    input  logic              [2:0] orientacao,
    input  logic              [2:0] k,
    output logic signed       [4:0] dx,
    output logic signed       [4:0] dy,
    output logic                    ultima
);

    // Offset lookup; orientation codes above 3 reuse the orientation-0 shape.
    always_comb begin
        dx     = 5'sd0;
        dy     = 5'sd0;
        ultima = (k == (tamanho_peca(tipo) - 3'd1));
        if (tipo == HIDROAVIAO) begin
            case (orientacao)
                3'd1: begin
                    case (k)
                        3'd1:    begin dx = 5'sd1;  dy = 5'sd1;  end
                        3'd2:    begin dx = 5'sd0;  dy = 5'sd2;  end
                        default: begin dx = 5'sd0;  dy = 5'sd0;  end
                    endcase
                end
                3'd2: begin
                    case (k)
                        3'd1:    begin dx = 5'sd1;  dy = -5'sd1; end
                        3'd2:    begin dx = 5'sd2;  dy = 5'sd0;  end
                        default: begin dx = 5'sd0;  dy = 5'sd0;  end
                    endcase
                end
                3'd3: begin
                    case (k)
                        3'd1:    begin dx = -5'sd1; dy = 5'sd1;  end
                        3'd2:    begin dx = 5'sd0;  dy = 5'sd2;  end
                        default: begin dx = 5'sd0;  dy = 5'sd0;  end
                    endcase
                end
                default: begin
                    case (k)
                        3'd1:    begin dx = 5'sd1;  dy = 5'sd1;  end
                        3'd2:    begin dx = 5'sd2;  dy = 5'sd0;  end
                        default: begin dx = 5'sd0;  dy = 5'sd0;  end
                    endcase
                end
            endcase
        end else begin
            if (direcao) begin
                dy = $signed({2'b00, k});
            end else begin
                dx = $signed({2'b00, k});
            end
        end
    end

endmodule

// File: rtl/validador_pecas.sv
// Piece validator and board storage. Optional VALIDADOR_ADJACENCIA_EN also
// tests the four orthogonal neighbours of every piece cell.
module validador_pecas
    import batalha_pkg::*;
#(
    parameter int LADO = LADO_PADRAO
)
(
    input  logic               clk,
    input  logic               reset,
    validador_pecas_if.slave   bus
);

    localparam int IW = $clog2(LADO * LADO);
    localparam logic signed [4:0] LADO_S = 5'(LADO);
    localparam logic        [3:0] LADO_U = 4'(LADO);

`ifdef VALIDADOR_ADJACENCIA_EN
    localparam logic [2:0] VIZ_ULT = 3'd4;
`else
    localparam logic [2:0] VIZ_ULT = 3'd0;
`endif

    function automatic logic [IW-1:0] indice(input logic [3:0] x, input logic [3:0] y);
        return IW'((({4'd0, y} - 8'd1) * 8'(LADO)) + ({4'd0, x} - 8'd1));
    endfunction

    estado_t           estado_r;
    estado_t           estado_next_s;
    logic              valida_q_r;
    logic        [2:0] tipo_r;
    logic        [3:0] x1_r;
    logic        [3:0] y1_r;
    logic              dir_r;
    logic        [2:0] ori_r;
    logic              jog_r;
    logic        [2:0] k_r;
    logic        [2:0] viz_r;
    logic              conflito_r;
    logic              verificado_r;
    logic              ocupado_r;
    logic              gravado_r;
    logic        [2:0] rd_celula_r;
    logic        [2:0] tab_r [2][LADO*LADO];

    logic signed [4:0] dx_s;
    logic signed [4:0] dy_s;
    logic              ultima_s;
    logic signed [4:0] vdx_s;
    logic signed [4:0] vdy_s;
    logic signed [4:0] loc_x_s;
    logic signed [4:0] loc_y_s;
    logic              dentro_s;
    logic     [IW-1:0] idx_s;
    logic              ocupada_s;
    logic              conflito_aqui_s;
    logic              fim_verif_s;
    logic              valida_sobe_s;
    logic              rd_ok_s;

    gerador_celulas u_gerador (
        .tipo       (tipo_r),
        .direcao    (dir_r),
        .orientacao (ori_r),
        .k          (k_r),
        .dx         (dx_s),
        .dy         (dy_s),
        .ultima     (ultima_s)
    );

    // Neighbour offset for the location currently tested (0 = the cell itself).
    always_comb begin
        vdx_s = 5'sd0;
        vdy_s = 5'sd0;
        case (viz_r)
            3'd1:    vdx_s = -5'sd1;
            3'd2:    vdx_s = 5'sd1;
            3'd3:    vdy_s = -5'sd1;
            3'd4:    vdy_s = 5'sd1;
            default: vdx_s = 5'sd0;
        endcase
    end

    // Out-of-range sums wrap to negative values, so they still fail the range test.
    assign loc_x_s         = $signed({1'b0, x1_r}) + dx_s + vdx_s;
    assign loc_y_s         = $signed({1'b0, y1_r}) + dy_s + vdy_s;
    assign dentro_s        = (loc_x_s >= 5'sd1) && (loc_x_s <= LADO_S) &&
                             (loc_y_s >= 5'sd1) && (loc_y_s <= LADO_S);
    assign idx_s           = indice(loc_x_s[3:0], loc_y_s[3:0]);
    assign ocupada_s       = dentro_s && (tab_r[jog_r][idx_s] != CELULA_VAZIA);
    // Off-board neighbours are skipped; only the piece cell itself must be on-board.
    assign conflito_aqui_s = (viz_r == 3'd0) ? (!dentro_s || ocupada_s) : ocupada_s;
    assign fim_verif_s     = ultima_s && (viz_r == VIZ_ULT);
    assign valida_sobe_s   = bus.valida && !valida_q_r;
    assign rd_ok_s         = (bus.rd_x != 4'd0) && (bus.rd_x <= LADO_U) &&
                             (bus.rd_y != 4'd0) && (bus.rd_y <= LADO_U);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r <= IDLE;
        end else begin
            estado_r <= estado_next_s;
        end
    end

    // FSM next-state; a store request outranks a falling valida.
    always_comb begin
        estado_next_s = estado_r;
        case (estado_r)
            IDLE: begin
                if (valida_sobe_s) begin
                    estado_next_s = VERIFICA;
                end else begin
                    estado_next_s = IDLE;
                end
            end
            VERIFICA: begin
                if (fim_verif_s) begin
                    estado_next_s = RESULTADO;
                end else begin
                    estado_next_s = VERIFICA;
                end
            end
            RESULTADO: begin
                if (bus.armazena) begin
                    if (conflito_r) begin
                        estado_next_s = IDLE;
                    end else begin
                        estado_next_s = GRAVA;
                    end
                end else if (!bus.valida) begin
                    estado_next_s = IDLE;
                end else begin
                    estado_next_s = RESULTADO;
                end
            end
            GRAVA: begin
                if (ultima_s) begin
                    estado_next_s = IDLE;
                end else begin
                    estado_next_s = GRAVA;
                end
            end
            default: estado_next_s = IDLE;
        endcase
    end

    // Piece latch, cell/neighbour walk, sticky conflict and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            valida_q_r   <= 1'b0;
            tipo_r       <= 3'd0;
            x1_r         <= 4'd0;
            y1_r         <= 4'd0;
            dir_r        <= 1'b0;
            ori_r        <= 3'd0;
            jog_r        <= 1'b0;
            k_r          <= 3'd0;
            viz_r        <= 3'd0;
            conflito_r   <= 1'b0;
            verificado_r <= 1'b0;
            ocupado_r    <= 1'b0;
            gravado_r    <= 1'b0;
        end else begin
            valida_q_r   <= bus.valida;
            verificado_r <= (estado_next_s == RESULTADO);
            ocupado_r    <= (estado_next_s == VERIFICA) || (estado_next_s == GRAVA);
            gravado_r    <= (estado_r == GRAVA) && ultima_s;
            case (estado_r)
                IDLE: begin
                    if (valida_sobe_s) begin
                        tipo_r     <= bus.tipo;
                        x1_r       <= bus.X1;
                        y1_r       <= bus.Y1;
                        dir_r      <= bus.direcao;
                        ori_r      <= bus.orientacao;
                        jog_r      <= bus.jogador;
                        k_r        <= 3'd0;
                        viz_r      <= 3'd0;
                        conflito_r <= 1'b0;
                    end
                end
                VERIFICA: begin
                    if (conflito_aqui_s) begin
                        conflito_r <= 1'b1;
                    end
                    if (viz_r == VIZ_ULT) begin
                        viz_r <= 3'd0;
                        k_r   <= fim_verif_s ? 3'd0 : (k_r + 3'd1);
                    end else begin
                        viz_r <= viz_r + 3'd1;
                    end
                end
                RESULTADO: k_r <= 3'd0;
                GRAVA:     k_r <= ultima_s ? 3'd0 : (k_r + 3'd1);
                default:   k_r <= 3'd0;
            endcase
        end
    end

    // Board storage: cleared on reset, one piece cell written per GRAVA cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < 2; j++) begin
                for (int i = 0; i < LADO * LADO; i++) begin
                    tab_r[j][i] <= CELULA_VAZIA;
                end
            end
        end else if ((estado_r == GRAVA) && dentro_s) begin
            tab_r[jog_r][idx_s] <= tipo_r + 3'd1;
        end
    end

    // Registered read port; a read colliding with a write sees the old content.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_celula_r <= CELULA_VAZIA;
        end else if (rd_ok_s) begin
            rd_celula_r <= tab_r[bus.rd_jogador][indice(bus.rd_x, bus.rd_y)];
        end else begin
            rd_celula_r <= CELULA_VAZIA;
        end
    end

    assign bus.conflito   = conflito_r;
    assign bus.verificado = verificado_r;
    assign bus.ocupado    = ocupado_r;
    assign bus.gravado    = gravado_r;
    assign bus.rd_celula  = rd_celula_r;

endmodule

// File: tb/tb_validador_pecas.sv
// Directed plus randomized bench for validador_pecas, checked against a
// coordinate-level board model.
module tb_validador_pecas;
    import batalha_pkg::*;

    logic clk = 1'b0;
    logic reset;

    validador_pecas_if bus ();

    validador_pecas #(.LADO(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef VALIDADOR_ADJACENCIA_EN
    localparam int PASSOS = 5;
`else
    localparam int PASSOS = 1;
`endif

    int total = 0;
    int bad   = 0;
    int mdl [2][10][10];
    int hx [4][3] = '{'{0, 1, 2}, '{0, 1, 0}, '{0, 1, 2}, '{0, -1, 0}};
    int hy [4][3] = '{'{0, 1, 0}, '{0, 1, 2}, '{0, -1, 0}, '{0, 1, 2}};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit dentro(input int x, input int y);
        return (x >= 1) && (x <= 8) && (y >= 1) && (y <= 8);
    endfunction

    function automatic bit ocupada(input int j, input int x, input int y);
        if (!dentro(x, y)) return 1'b0;
        return mdl[j][x][y] != 0;
    endfunction

    function automatic void celula(input int t, input int x, input int y, input int d,
                                   input int o, input int k, output int cx, output int cy);
        int oo;
        if (t == 2) begin
            oo = (o > 3) ? 0 : o;
            cx = x + hx[oo][k];
            cy = y + hy[oo][k];
        end else if (d == 1) begin
            cx = x;
            cy = y + k;
        end else begin
            cx = x + k;
            cy = y;
        end
    endfunction

    function automatic bit conflito_ref(input int j, input int t, input int x, input int y,
                                        input int d, input int o);
        int cx, cy;
        bit r = 1'b0;
        for (int k = 0; k < t + 1; k++) begin
            celula(t, x, y, d, o, k, cx, cy);
            if (!dentro(cx, cy) || ocupada(j, cx, cy)) r = 1'b1;
            if (PASSOS == 5) begin
                if (ocupada(j, cx - 1, cy) || ocupada(j, cx + 1, cy) ||
                    ocupada(j, cx, cy - 1) || ocupada(j, cx, cy + 1)) r = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic escreve_ref(input int j, input int t, input int x, input int y,
                               input int d, input int o);
        int cx, cy;
        for (int k = 0; k < t + 1; k++) begin
            celula(t, x, y, d, o, k, cx, cy);
            mdl[j][cx][cy] = t + 1;
        end
    endtask

    task automatic le(input int j, input int x, input int y, output logic [2:0] c);
        bus.rd_jogador = j[0];
        bus.rd_x       = x[3:0];
        bus.rd_y       = y[3:0];
        tick;
        c = bus.rd_celula;
    endtask

    task automatic confere_tabuleiro(input string tag);
        logic [2:0] c;
        for (int j = 0; j < 2; j++)
            for (int x = 1; x <= 8; x++)
                for (int y = 1; y <= 8; y++) begin
                    le(j, x, y, c);
                    chk($sformatf("%s j%0d (%0d,%0d)", tag, j, x, y), 32'(c), mdl[j][x][y]);
                end
    endtask

    task automatic poe_peca(input int j, input int t, input int x, input int y,
                            input int d, input int o);
        bus.jogador    = j[0];
        bus.tipo       = t[2:0];
        bus.X1         = x[3:0];
        bus.Y1         = y[3:0];
        bus.direcao    = d[0];
        bus.orientacao = o[2:0];
    endtask

    task automatic verifica(input string tag, input int j, input int t, input int x, input int y,
                            input int d, input int o, input bit guardar, input bit embaralhar);
        bit exp_c;
        int n;
        int cnt;
        exp_c = conflito_ref(j, t, x, y, d, o);
        n     = t + 1;
        poe_peca(j, t, x, y, d, o);
        bus.valida = 1'b1;
        tick;
        chk({tag, " ocupado"}, 32'(bus.ocupado), 32'd1);
        if (embaralhar)
            poe_peca($urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 9),
                     $urandom_range(0, 9), $urandom_range(0, 1), $urandom_range(0, 4));
        cnt = 0;
        while (bus.verificado !== 1'b1 && cnt < 60) begin
            tick;
            cnt++;
        end
        chk({tag, " latencia"}, cnt, n * PASSOS);
        chk({tag, " conflito"}, 32'(bus.conflito), 32'(exp_c));
        if (guardar) begin
            bus.armazena = 1'b1;
            tick;
            bus.armazena = 1'b0;
            if (exp_c) begin
                tick;
                tick;
                chk({tag, " recusa ocupado"}, 32'(bus.ocupado), 32'd0);
                chk({tag, " recusa verificado"}, 32'(bus.verificado), 32'd0);
            end else begin
                cnt = 1;
                while (bus.gravado !== 1'b1 && cnt < 60) begin
                    tick;
                    cnt++;
                end
                chk({tag, " gravado latencia"}, cnt, n + 1);
                escreve_ref(j, t, x, y, d, o);
                tick;
                chk({tag, " gravado pulso"}, 32'(bus.gravado), 32'd0);
                chk({tag, " sem redisparo"}, 32'(bus.ocupado), 32'd0);
            end
        end
        bus.valida = 1'b0;
        tick;
        chk({tag, " verificado cai"}, 32'(bus.verificado), 32'd0);
        chk({tag, " conflito retido"}, 32'(bus.conflito), 32'(exp_c));
    endtask

    initial begin
        logic [2:0] c;
        int cnt;
        bus.valida = 1'b0;
        bus.armazena = 1'b0;
        poe_peca(0, 0, 0, 0, 0, 0);
        bus.rd_jogador = 1'b0;
        bus.rd_x = 4'd0;
        bus.rd_y = 4'd0;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        chk("reset conflito", 32'(bus.conflito), 32'd0);
        chk("reset ocupado", 32'(bus.ocupado), 32'd0);
        chk("reset verificado", 32'(bus.verificado), 32'd0);
        chk("reset gravado", 32'(bus.gravado), 32'd0);
        confere_tabuleiro("reset");

        verifica("pa_j0", 0, 4, 1, 1, 0, 0, 1'b1, 1'b0);
        for (int x = 1; x <= 5; x++) begin
            le(0, x, 1, c);
            chk($sformatf("pa_j0 cel %0d", x), 32'(c), 32'd5);
        end
        le(0, 6, 1, c);
        chk("pa_j0 cel 6", 32'(c), 32'd0);

        verifica("cruz_sobre", 0, 1, 3, 1, 1, 0, 1'b1, 1'b0);
        confere_tabuleiro("cruz_sobre");
        verifica("enc_borda", 0, 3, 6, 2, 0, 0, 1'b0, 1'b0);
        verifica("hidro_or2", 0, 2, 1, 1, 0, 2, 1'b0, 1'b0);
        verifica("x1_zero", 0, 0, 0, 4, 0, 0, 1'b0, 1'b0);
        verifica("pa_j1", 1, 4, 1, 1, 0, 0, 1'b1, 1'b0);
        confere_tabuleiro("pa_j1");
        verifica("sub_vizinho", 0, 0, 6, 1, 0, 0, 1'b0, 1'b0);

        // reset during the third GRAVA cycle
        poe_peca(1, 4, 1, 3, 0, 0);
        bus.valida = 1'b1;
        tick;
        cnt = 0;
        while (bus.verificado !== 1'b1 && cnt < 60) begin
            tick;
            cnt++;
        end
        chk("rst_grava latencia", cnt, 5 * PASSOS);
        bus.armazena = 1'b1;
        tick;
        bus.armazena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("rst_grava sem gravado", 32'(bus.gravado), 32'd0);
        end
        bus.valida = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int j = 0; j < 2; j++)
            for (int x = 0; x < 10; x++)
                for (int y = 0; y < 10; y++) mdl[j][x][y] = 0;
        chk("rst_grava gravado", 32'(bus.gravado), 32'd0);
        chk("rst_grava ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_grava verificado", 32'(bus.verificado), 32'd0);
        tick;
        chk("rst_grava gravado depois", 32'(bus.gravado), 32'd0);
        confere_tabuleiro("rst_grava");
        verifica("pos_reset", 0, 1, 2, 2, 1, 0, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++)
            verifica($sformatf("aleatorio %0d", i), $urandom_range(0, 1), $urandom_range(0, 4),
                     $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 1),
                     $urandom_range(0, 4), $urandom_range(0, 1), 1'b1);
        confere_tabuleiro("aleatorio");

        le(0, 0, 1, c);
        chk("leitura x0", 32'(c), 32'd0);
        le(1, 9, 2, c);
        chk("leitura x9", 32'(c), 32'd0);
        le(0, 3, 0, c);
        chk("leitura y0", 32'(c), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
